// File: rtl/tff_count_pkg.sv
// tff_count_pkg: shared state encoding and control constants for the T-cell counter
package tff_count_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT = 1'b1;
  localparam int WIDTH_DEF = 4;
endpackage

// File: rtl/tff_count_ctrl_cell.sv
// tff_cell: single T flip-flop storage bit with asynchronous active-low clear
module tff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= 1'b0;
    else q <= q ^ t;
endmodule

// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: run FSM sequencing a T-cell bank as a programmable up/down counter
module tff_count_ctrl
  import tff_count_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tc,
  output logic             done
);
  state_t state, nxt;
  logic dir_r, mode_r, ld;
  logic [WIDTH-1:0] limit_r, t, step_t, start_val, term;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      dir_r <= DIR_UP;
      mode_r <= MODE_ONESHOT;
      limit_r <= '0;
    end else begin
      state <= nxt;
      if (ld) {dir_r, mode_r, limit_r} <= {dir, mode, limit};
    end
  assign start_val = dir_r == DIR_DOWN ? limit_r : '0;
  assign term = dir_r == DIR_DOWN ? '0 : limit_r;
  assign busy = state != IDLE;
  assign tc = state == RUN && count == term;
  assign done = state == DONE;
  // toggle carry chain: bit i flips when all lower bits are 1 (up) or 0 (down)
  always_comb begin : step_chain
    logic cu, cd;
    step_t = '0;
    cu = 1'b1;
    cd = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step_t[i] = dir_r == DIR_DOWN ? cd : cu;
      cu = cu & count[i];
      cd = cd & ~count[i];
    end
  end
  always_comb begin
    nxt = state;
    t = '0;
    ld = 1'b0;
    unique case (state)
      IDLE: if (start && !stop) begin
        nxt = RUN;
        ld = 1'b1;
        t = count ^ (dir == DIR_DOWN ? limit : '0);
      end
      RUN: if (stop) nxt = IDLE;
        else if (tc) begin
          nxt = mode_r == MODE_ONESHOT ? DONE : RUN;
          t = mode_r == MODE_CONT ? count ^ start_val : '0;
        end else t = step_t;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    tff_cell u_cell (.clk(clk), .reset(reset), .t(t[g]), .q(count[g]));
  end
endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb_tff_count_ctrl: directed vectors with a queue-based scoreboard for tff_count_ctrl
module tb_tff_count_ctrl;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0, dir = 1'b0, mode = 1'b0;
  logic [3:0] limit = '0, count;
  logic busy, tc, done;
  int total = 0, bad = 0;
  typedef struct {
    string nm;
    logic [3:0] c;
    logic b, t, d;
  } exp_t;
  exp_t q[$];

  tff_count_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .dir(dir), .mode(mode),
    .limit(limit), .count(count), .busy(busy), .tc(tc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] c, input logic b, t, d);
    total++;
    if (count !== c || busy !== b || tc !== t || done !== d) begin
      bad++;
      $display("FAIL %s: got count=%0d busy=%b tc=%b done=%b, want count=%0d busy=%b tc=%b done=%b",
               nm, count, busy, tc, done, c, b, t, d);
    end
  endtask

  // drive inputs for the next edge and queue what the outputs must be after it
  task automatic cyc(input logic s, p, d, m, input logic [3:0] l,
                     input logic [3:0] c, input logic b, t, dn, input string nm);
    @(negedge clk);
    start = s; stop = p; dir = d; mode = m; limit = l;
    q.push_back('{nm, c, b, t, dn});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, e.c, e.b, e.t, e.d);
      end
    end
  end

  initial begin : stim
    #1 chk("reset_init", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_after_reset");
    // one-shot up to 5
    cyc(1, 0, 0, 0, 5, 0, 1, 0, 0, "os_up_load");
    for (int n = 1; n <= 5; n++) cyc(0, 0, 0, 0, 5, 4'(n), 1, n == 5, 0, "os_up_step");
    cyc(0, 0, 0, 0, 5, 5, 1, 0, 1, "os_up_done");
    cyc(0, 0, 0, 0, 5, 5, 0, 0, 0, "os_up_idle");
    cyc(0, 0, 0, 0, 5, 5, 0, 0, 0, "os_up_hold");
    // continuous down from 3
    cyc(1, 0, 1, 1, 3, 3, 1, 0, 0, "cd_load");
    for (int n = 1; n < 8; n++) cyc(0, 0, 1, 1, 3, 4'(3 - n % 4), 1, n % 4 == 3, 0, "cd_step");
    cyc(0, 1, 1, 1, 3, 0, 0, 0, 0, "cd_stop");
    // stop mid-run, then start+stop collision in idle
    cyc(1, 0, 0, 0, 9, 0, 1, 0, 0, "stop_load");
    cyc(0, 0, 0, 0, 9, 1, 1, 0, 0, "stop_step1");
    cyc(0, 0, 0, 0, 9, 2, 1, 0, 0, "stop_step2");
    cyc(0, 1, 0, 0, 9, 2, 0, 0, 0, "stop_run");
    cyc(1, 1, 0, 0, 9, 2, 0, 0, 0, "start_stop_idle");
    cyc(1, 1, 1, 1, 9, 2, 0, 0, 0, "start_stop_idle2");
    // start and setting changes ignored while busy
    cyc(1, 0, 0, 0, 4, 0, 1, 0, 0, "ign_load");
    cyc(1, 0, 1, 1, 7, 1, 1, 0, 0, "ign_restart");
    for (int n = 2; n <= 4; n++) cyc(0, 0, 1, 1, 7, 4'(n), 1, n == 4, 0, "ign_step");
    cyc(1, 0, 0, 0, 7, 4, 1, 0, 1, "ign_done");
    cyc(1, 0, 0, 0, 7, 4, 0, 0, 0, "ign_start_in_done");
    cyc(1, 0, 0, 0, 7, 0, 1, 0, 0, "new_load");
    for (int n = 1; n <= 7; n++) cyc(0, 0, 0, 0, 7, 4'(n), 1, n == 7, 0, "new_step");
    cyc(0, 0, 0, 0, 7, 7, 1, 0, 1, "new_done");
    cyc(0, 0, 0, 0, 7, 7, 0, 0, 0, "new_idle");
    // limit 0, one-shot up then continuous down
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, "lim0_tc");
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, "lim0_done");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, "lim0_idle");
    cyc(1, 0, 1, 1, 0, 0, 1, 1, 0, "lim0_dn_load");
    cyc(0, 0, 1, 1, 0, 0, 1, 1, 0, "lim0_dn_hold");
    cyc(0, 0, 1, 1, 0, 0, 1, 1, 0, "lim0_dn_hold2");
    cyc(0, 1, 1, 1, 0, 0, 0, 0, 0, "lim0_dn_stop");
    // full-range continuous up
    for (int i = 0; i <= 32; i++) cyc(i == 0, 0, 0, 1, 15, 4'(i % 16), 1, i % 16 == 15, 0, "full_wrap");
    cyc(0, 1, 0, 1, 15, 0, 0, 0, 0, "full_stop");
    // asynchronous reset mid-run at count 5
    cyc(1, 0, 0, 0, 9, 0, 1, 0, 0, "rst_load");
    for (int n = 1; n <= 5; n++) cyc(0, 0, 0, 0, 9, 4'(n), 1, 0, 0, "rst_step");
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk) reset = 1'b1;
    cyc(0, 0, 0, 0, 9, 0, 0, 0, 0, "rst_idle");
    cyc(0, 0, 0, 0, 9, 0, 0, 0, 0, "rst_idle2");
    @(posedge clk);
    #3;
    if (q.size() != 0) begin
      bad++;
      total++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
